// File: rtl/decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_stage_pkg
// Shared definitions for the decode stage: datapath widths, instruction
// field positions, the NOP encoding, opcode encodings, the opcode-class
// decode function and the branch-FSM state encoding.
// ---------------------------------------------------------------------------
package decode_stage_pkg;

    localparam int PC_WIDTH  = 16;
    localparam int IR_WIDTH  = 32;
    localparam int REG_WIDTH = 16;
    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 4;

    // Instruction field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 24;
    localparam int RD_HI  = 23;
    localparam int RD_LO  = 20;
    localparam int RS1_HI = 19;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 11;
    localparam int RS2_LO = 8;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [IR_WIDTH-1:0] NOP_IR = 32'hFF000000;

    // Opcode encodings
    localparam logic [7:0] OP_ADD  = 8'h01;  // rd = rs1 + rs2
    localparam logic [7:0] OP_ADDI = 8'h02;  // rd = rs1 + imm
    localparam logic [7:0] OP_MOVI = 8'h03;  // rd = imm
    localparam logic [7:0] OP_BR   = 8'h10;  // unconditional branch
    localparam logic [7:0] OP_BRZ  = 8'h11;  // branch if rs1 == 0
    localparam logic [7:0] OP_ST   = 8'h20;  // mem[rs1] = rs2
    localparam logic [7:0] OP_NOP  = 8'hFF;

    typedef struct packed {
        logic writes_rd;
        logic uses_src1;
        logic uses_src2;
        logic is_branch;
    } op_class_t;

    typedef enum logic {
        BR_IDLE = 1'b0,
        BR_WAIT = 1'b1
    } br_state_e;

    // NOP and anything unrecognised decode to "touches nothing".
    function automatic op_class_t decode_class(input logic [7:0] opc);
        op_class_t c;
        c = '0;
        case (opc)
            OP_ADD:  c = '{writes_rd: 1'b1, uses_src1: 1'b1, uses_src2: 1'b1, is_branch: 1'b0};
            OP_ADDI: c = '{writes_rd: 1'b1, uses_src1: 1'b1, uses_src2: 1'b0, is_branch: 1'b0};
            OP_MOVI: c = '{writes_rd: 1'b1, uses_src1: 1'b0, uses_src2: 1'b0, is_branch: 1'b0};
            OP_BR:   c = '{writes_rd: 1'b0, uses_src1: 1'b0, uses_src2: 1'b0, is_branch: 1'b1};
            OP_BRZ:  c = '{writes_rd: 1'b0, uses_src1: 1'b1, uses_src2: 1'b0, is_branch: 1'b1};
            OP_ST:   c = '{writes_rd: 1'b0, uses_src1: 1'b1, uses_src2: 1'b1, is_branch: 1'b0};
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_scoreboard.sv
// ---------------------------------------------------------------------------
// scoreboard
// Per-register 2-bit pending-write counters for the decode stage.
// Ports:
//   clk_i      stage clock (state updates on the falling edge)
//   rst_i      synchronous active-high reset, clears all counts
//   en_i       pipeline enable; counts hold while low
//   inc_en_i   an instruction that writes inc_reg_i is issuing
//   inc_reg_i  destination register of the issuing instruction
//   dec_en_i   writeback strobe
//   dec_reg_i  writeback destination register
//   rd_a_i/rd_b_i/rd_c_i    lookup register indices
//   pend_a_o/pend_b_o/pend_c_o  pending counts for those registers
// ---------------------------------------------------------------------------
module scoreboard
    import decode_stage_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 inc_en_i,
    input  logic [REG_IDX_W-1:0] inc_reg_i,
    input  logic                 dec_en_i,
    input  logic [REG_IDX_W-1:0] dec_reg_i,
    input  logic [REG_IDX_W-1:0] rd_a_i,
    input  logic [REG_IDX_W-1:0] rd_b_i,
    input  logic [REG_IDX_W-1:0] rd_c_i,
    output logic [1:0]           pend_a_o,
    output logic [1:0]           pend_b_o,
    output logic [1:0]           pend_c_o
);

    logic [NUM_REGS-1:0][1:0] pend_q;
    logic [NUM_REGS-1:0][1:0] pend_d;

    // An issue and a writeback hitting the same register cancel out.
    // The counter saturates at 3 (decode never issues a writer at 3) and
    // a writeback at 0 is ignored so a stray strobe cannot wrap it.
    always_comb begin
        pend_d = pend_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (inc_en_i && inc_reg_i == 4'(r) && !(dec_en_i && dec_reg_i == 4'(r))) begin
                if (pend_q[r] != 2'd3) begin
                    pend_d[r] = pend_q[r] + 2'd1;
                end
            end else if (dec_en_i && dec_reg_i == 4'(r) && !(inc_en_i && inc_reg_i == 4'(r))) begin
                if (pend_q[r] != 2'd0) begin
                    pend_d[r] = pend_q[r] - 2'd1;
                end
            end
        end
    end

    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else if (en_i) begin
            pend_q <= pend_d;
        end
    end

    assign pend_a_o = pend_q[rd_a_i];
    assign pend_b_o = pend_q[rd_b_i];
    assign pend_c_o = pend_q[rd_c_i];

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Decode stage of the GPU-frame core. Latches PC/IR/valid from fetch into
// the DL latch, classifies the opcode, reads a 16x16-bit register file
// (with writeback bypass), tracks pending writes in a scoreboard and
// issues decoded operands to execute. Dependency and branch stalls are
// reported back to fetch. All state changes on the falling clock edge.
// Ports:
//   I_CLOCK, I_RESET (sync, active-high), I_LOCK (pipeline enable)
//   I_PC, I_IR, I_FE_Valid            fetch output
//   I_BranchAddrSelect                branch resolved (memory stage)
//   I_WB_Enable, I_WB_Reg, I_WB_Data  register-file writeback
//   O_LOCK                            registered I_LOCK
//   O_BranchStallSignal, O_DepStallSignal  stalls toward fetch
//   O_DE_Valid, O_PC, O_IR, O_Opcode, O_DestReg,
//   O_Src1Value, O_Src2Value, O_Imm   issued instruction to execute
// ---------------------------------------------------------------------------
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic                 I_CLOCK,
    input  logic                 I_RESET,
    input  logic                 I_LOCK,
    input  logic [PC_WIDTH-1:0]  I_PC,
    input  logic [IR_WIDTH-1:0]  I_IR,
    input  logic                 I_FE_Valid,
    input  logic                 I_BranchAddrSelect,
    input  logic                 I_WB_Enable,
    input  logic [REG_IDX_W-1:0] I_WB_Reg,
    input  logic [REG_WIDTH-1:0] I_WB_Data,
    output logic                 O_LOCK,
    output logic                 O_BranchStallSignal,
    output logic                 O_DepStallSignal,
    output logic                 O_DE_Valid,
    output logic [PC_WIDTH-1:0]  O_PC,
    output logic [IR_WIDTH-1:0]  O_IR,
    output logic [7:0]           O_Opcode,
    output logic [REG_IDX_W-1:0] O_DestReg,
    output logic [REG_WIDTH-1:0] O_Src1Value,
    output logic [REG_WIDTH-1:0] O_Src2Value,
    output logic [15:0]          O_Imm
);

    // DL latch
    logic [PC_WIDTH-1:0]  dl_pc_q,  dl_pc_d;
    logic [IR_WIDTH-1:0]  dl_ir_q,  dl_ir_d;
    logic                 dl_vld_q, dl_vld_d;

    // Branch FSM
    br_state_e            state_q, state_d;

    // Register file
    logic [REG_WIDTH-1:0] rf_q [NUM_REGS];

    // Issue output registers
    logic                 lock_q;
    logic                 de_vld_q, de_vld_d;
    logic [PC_WIDTH-1:0]  pc_q,     pc_d;
    logic [IR_WIDTH-1:0]  ir_q,     ir_d;
    logic [REG_WIDTH-1:0] src1_q,   src1_d;
    logic [REG_WIDTH-1:0] src2_q,   src2_d;

    // Decode of the instruction sitting in DL
    op_class_t            dl_cls;
    logic [REG_IDX_W-1:0] dl_rd, dl_rs1, dl_rs2;
    logic [1:0]           pend_rd, pend_rs1, pend_rs2;
    logic                 dep_stall, br_stall, issue;
    logic [REG_WIDTH-1:0] rs1_val, rs2_val;

    assign dl_cls = decode_class(dl_ir_q[OPC_HI:OPC_LO]);
    assign dl_rd  = dl_ir_q[RD_HI:RD_LO];
    assign dl_rs1 = dl_ir_q[RS1_HI:RS1_LO];
    assign dl_rs2 = dl_ir_q[RS2_HI:RS2_LO];

    scoreboard u_sb (
        .clk_i     (I_CLOCK),
        .rst_i     (I_RESET),
        .en_i      (I_LOCK),
        .inc_en_i  (issue & dl_cls.writes_rd),
        .inc_reg_i (dl_rd),
        .dec_en_i  (I_WB_Enable),
        .dec_reg_i (I_WB_Reg),
        .rd_a_i    (dl_rs1),
        .rd_b_i    (dl_rs2),
        .rd_c_i    (dl_rd),
        .pend_a_o  (pend_rs1),
        .pend_b_o  (pend_rs2),
        .pend_c_o  (pend_rd)
    );

    // A writer is also held when its destination already has three writes
    // in flight, since the counter cannot represent a fourth.
    assign dep_stall = dl_vld_q &
                       ((dl_cls.uses_src1 & (pend_rs1 != 2'd0)) |
                        (dl_cls.uses_src2 & (pend_rs2 != 2'd0)) |
                        (dl_cls.writes_rd & (pend_rd == 2'd3)));
    assign br_stall  = (state_q == BR_WAIT);
    assign issue     = dl_vld_q & ~dep_stall & ~br_stall & I_LOCK;

    // Same-cycle writeback is forwarded so the issued operand is current.
    assign rs1_val = (I_WB_Enable && I_WB_Reg == dl_rs1) ? I_WB_Data : rf_q[dl_rs1];
    assign rs2_val = (I_WB_Enable && I_WB_Reg == dl_rs2) ? I_WB_Data : rf_q[dl_rs2];

    // Branch FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            BR_IDLE: if (issue && dl_cls.is_branch) state_d = BR_WAIT;
            BR_WAIT: if (I_BranchAddrSelect)        state_d = BR_IDLE;
            default: state_d = BR_IDLE;
        endcase
    end

    // DL next state. During branch wait the word in DL (and whatever fetch
    // presents) is wrong-path, so it is squashed before the dep-stall hold
    // gets a chance to keep it.
    always_comb begin
        dl_pc_d  = dl_pc_q;
        dl_ir_d  = dl_ir_q;
        dl_vld_d = dl_vld_q;
        if (br_stall) begin
            dl_pc_d  = '0;
            dl_ir_d  = NOP_IR;
            dl_vld_d = 1'b0;
        end else if (!dep_stall) begin
            dl_pc_d  = I_PC;
            dl_ir_d  = I_IR;
            dl_vld_d = I_FE_Valid;
        end
    end

    // Issue outputs: a bubble carries the reset image (PC 0, NOP, zeros).
    always_comb begin
        de_vld_d = 1'b0;
        pc_d     = '0;
        ir_d     = NOP_IR;
        src1_d   = '0;
        src2_d   = '0;
        if (issue) begin
            de_vld_d = 1'b1;
            pc_d     = dl_pc_q;
            ir_d     = dl_ir_q;
            src1_d   = rs1_val;
            src2_d   = rs2_val;
        end
    end

    // ---- DL / FSM / issue register boundary ----
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            state_q  <= BR_IDLE;
            dl_pc_q  <= '0;
            dl_ir_q  <= NOP_IR;
            dl_vld_q <= 1'b0;
            lock_q   <= 1'b0;
            de_vld_q <= 1'b0;
            pc_q     <= '0;
            ir_q     <= NOP_IR;
            src1_q   <= '0;
            src2_q   <= '0;
        end else begin
            lock_q   <= I_LOCK;
            de_vld_q <= de_vld_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            if (I_LOCK) begin
                state_q  <= state_d;
                dl_pc_q  <= dl_pc_d;
                dl_ir_q  <= dl_ir_d;
                dl_vld_q <= dl_vld_d;
            end
        end
    end

    // ---- register file write boundary (writeback lands even when locked) ----
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                rf_q[r] <= '0;
            end
        end else if (I_WB_Enable) begin
            rf_q[I_WB_Reg] <= I_WB_Data;
        end
    end

    assign O_LOCK              = lock_q;
    assign O_BranchStallSignal = br_stall;
    assign O_DepStallSignal    = dep_stall;
    assign O_DE_Valid          = de_vld_q;
    assign O_PC                = pc_q;
    assign O_IR                = ir_q;
    assign O_Opcode            = ir_q[OPC_HI:OPC_LO];
    assign O_DestReg           = ir_q[RD_HI:RD_LO];
    assign O_Src1Value         = src1_q;
    assign O_Src2Value         = src2_q;
    assign O_Imm               = ir_q[IMM_HI:IMM_LO];

endmodule
